riscof_sig_monitor: RTL
=======================

Name: riscof_sig_monitor

Overview:
- Synthesizable compliance-run monitor; replaces the simulation-only halt polling and signature dump loop in the riscof benches.
- Snoops the core's data-bus writes to three parametrised MMIO cells: halt, signature start and signature end.
- Enforces a cycle timeout, then reads the signature region back through a dedicated memory read port.
- Streams signature words out over a valid/ready interface, so the same bench runs on Verilator, FPGA or UART dump.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8
ADDR_WIDTH, 32, byte address width
HALT_ADDR, 32'h001F_FFF4, byte address of halt cell
SIG_END_ADDR, 32'h001F_FFF8, byte address of signature-end cell
SIG_START_ADDR, 32'h001F_FFFC, byte address of signature-start cell
TIMEOUT, 1000000, cycles in RUN before timeout; must be >= 1
MAX_SIG_WORDS, 65536, largest legal signature length in words

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
snoop_req_i  in  1  data-bus request strobe
snoop_we_i  in  DATA_WIDTH/8  byte write enables
snoop_addr_i  in  ADDR_WIDTH  data-bus byte address
snoop_wdata_i  in  DATA_WIDTH  data-bus write data
mem_req_o  out  1  read request, single-cycle pulse
mem_addr_o  out  ADDR_WIDTH  read byte address
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_WIDTH  read data
mem_err_i  in  1  read error, qualified by mem_rvalid_i
sig_valid_o  out  1  signature word valid
sig_data_o  out  DATA_WIDTH  signature word
sig_ready_i  in  1  sink ready
done_o  out  1  run finished; sticky until reset
status_o  out  2  0 running, 1 pass-dumped, 2 timeout, 3 error
sig_count_o  out  ADDR_WIDTH  words emitted so far

Behaviour:
- Reset (async assert, sync deassert by caller): state RUN; start/end registers 0; cycle counter 0. All outputs 0: mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, status_o, sig_count_o.
- Snooped write = snoop_req_i && snoop_we_i == all-ones. Partial-byte writes to the cells are ignored.
- Write to SIG_START_ADDR or SIG_END_ADDR latches wdata into that register. Accepted in RUN only.
- Halt = snooped write to HALT_ADDR with wdata == 1. Any other value is ignored.
- States: RUN, CHECK, REQ, WAIT, EMIT, DONE.
- RUN: counter increments each cycle.
  - Halt -> CHECK. Halt wins if it coincides with timeout.
  - Counter == TIMEOUT-1 without halt -> DONE, status 2.
- CHECK, one cycle:
  - start[1:0] != 0, end[1:0] != 0, start > end, or (end-start)>>2 > MAX_SIG_WORDS -> DONE, status 3.
  - start == end -> DONE, status 1, zero words emitted.
  - Otherwise cur = start -> REQ.
- REQ: mem_req_o=1, mem_addr_o=cur for exactly one cycle -> WAIT.
- WAIT: hold until mem_rvalid_i.
  - mem_err_i -> DONE, status 3; nothing emitted.
  - Otherwise register rdata into sig_data_o, assert sig_valid_o -> EMIT.
- EMIT: sig_data_o held stable while valid && !ready.
  - On handshake: sig_valid_o drops, sig_count_o++, cur += 4.
  - cur+4 == end -> DONE, status 1; else -> REQ.
  - Minimum 3 cycles per word.
- DONE: done_o=1; status and count frozen; snoop writes ignored; only reset exits.
- Address arithmetic is modulo 2^ADDR_WIDTH; the CHECK rules exclude wrap-around.
- Reset mid-read: a late mem_rvalid_i after reset is ignored, because RUN does not sample it.

Optional Feature:
- Macro RISCOF_SIG_MON_CONSOLE_EN.
- When defined, adds ports console_valid_o (1, out), console_data_o (8, out), console_ready_i (1, in) and parameter CONSOLE_ADDR, default 32'h001F_FFF0.
- Any write with snoop_we_i[0] set to CONSOLE_ADDR pushes wdata[7:0] into a 16-entry FIFO drained by the console stream.
- Write while the FIFO is full: the byte is dropped and a sticky overflow bit is set; status 3 is reported at DONE if no other error occurred.
- FIFO keeps draining in all states, including DONE.
- When undefined, the ports, parameter and logic are absent.

Decomposition:
- Package riscof_sig_monitor_pkg: state enum, status codes (STAT_RUN, STAT_PASS, STAT_TIMEOUT, STAT_ERR) and default cell addresses.
- One sub-module when the console is enabled: riscof_console_fifo, a parametrised-depth sync FIFO with full/empty flags.

Test Plan:
- Write start=0x1000, end=0x1010, then halt=1; memory returns 0xA0..0xA3 -> four words streamed in order, sig_count_o=4, status 1, done_o=1.
- Same run with sig_ready_i low for 5 cycles on word 2 -> sig_data_o held at 0xA1 throughout, no duplicates or loss.
- No halt, TIMEOUT=100 -> done_o rises exactly 100 cycles after reset release, status 2, mem_req_o never asserted.
- start=0x1002 or start>end or start==end -> status 3, 3, 1 respectively; zero words emitted.
- mem_err_i on the second read -> status 3, sig_count_o=1.
- Assert rst_i during WAIT, then rvalid arrives -> all outputs 0, state RUN, rvalid ignored; the next full run passes.

Source files
------------

// File: rtl/riscof_sig_monitor_pkg.sv
// Shared types and defaults for the riscof compliance-run monitor.
// Console cell default exists only with RISCOF_SIG_MON_CONSOLE_EN.
package riscof_sig_monitor_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_e;

    localparam logic [1:0] STAT_RUN     = 2'd0;
    localparam logic [1:0] STAT_PASS    = 2'd1;
    localparam logic [1:0] STAT_TIMEOUT = 2'd2;
    localparam logic [1:0] STAT_ERR     = 2'd3;

    localparam logic [31:0] HALT_ADDR_DEF      = 32'h001F_FFF4;
    localparam logic [31:0] SIG_END_ADDR_DEF   = 32'h001F_FFF8;
    localparam logic [31:0] SIG_START_ADDR_DEF = 32'h001F_FFFC;
`ifdef RISCOF_SIG_MON_CONSOLE_EN
    localparam logic [31:0] CONSOLE_ADDR_DEF   = 32'h001F_FFF0;
`endif

endpackage

// File: rtl/riscof_console_fifo.sv
// Sync FIFO for console bytes; DEPTH must be a power of two.
// Built only when RISCOF_SIG_MON_CONSOLE_EN is defined.
`ifdef RISCOF_SIG_MON_CONSOLE_EN
module riscof_console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;

    assign empty_o = (r_wp == r_rp);
    assign full_o  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign data_o  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o)
            r_mem[r_wp[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push_i && !full_o)
                r_wp <= r_wp + 1'b1;
            if (pop_i && !empty_o)
                r_rp <= r_rp + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/riscof_sig_monitor.sv
// Snoops halt/signature MMIO cells, enforces a timeout and streams the signature.
// Optional console byte stream under RISCOF_SIG_MON_CONSOLE_EN.
module riscof_sig_monitor
    import riscof_sig_monitor_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = ADDR_WIDTH'(HALT_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] SIG_END_ADDR   = ADDR_WIDTH'(SIG_END_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] SIG_START_ADDR = ADDR_WIDTH'(SIG_START_ADDR_DEF),
`ifdef RISCOF_SIG_MON_CONSOLE_EN
    parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR   = ADDR_WIDTH'(CONSOLE_ADDR_DEF),
`endif
    parameter int TIMEOUT        = 1000000,
    parameter int MAX_SIG_WORDS  = 65536
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    snoop_req_i,
    input  logic [DATA_WIDTH/8-1:0] snoop_we_i,
    input  logic [ADDR_WIDTH-1:0]   snoop_addr_i,
    input  logic [DATA_WIDTH-1:0]   snoop_wdata_i,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i,
    output logic                    sig_valid_o,
    output logic [DATA_WIDTH-1:0]   sig_data_o,
    input  logic                    sig_ready_i,
`ifdef RISCOF_SIG_MON_CONSOLE_EN
    output logic                    console_valid_o,
    output logic [7:0]              console_data_o,
    input  logic                    console_ready_i,
`endif
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic [ADDR_WIDTH-1:0]   sig_count_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [ADDR_WIDTH-1:0] r_cur;

    logic                  w_wr;
    logic                  w_halt;
    logic [ADDR_WIDTH-1:0] w_words;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_bad;
    logic [1:0]            w_pass_stat;

    assign w_wr    = snoop_req_i && (&snoop_we_i);
    assign w_halt  = w_wr && (snoop_addr_i == HALT_ADDR) &&
                     (snoop_wdata_i == DATA_WIDTH'(1));
    assign w_words = (r_end - r_start) >> 2;
    assign w_next  = r_cur + ADDR_WIDTH'(4);
    assign w_bad   = (r_start[1:0] != 2'b00) || (r_end[1:0] != 2'b00) ||
                     (r_start > r_end) ||
                     (w_words > ADDR_WIDTH'(MAX_SIG_WORDS));

`ifdef RISCOF_SIG_MON_CONSOLE_EN
    logic w_con_push;
    logic w_con_full;
    logic w_con_empty;
    logic r_ovf;

    assign w_con_push = snoop_req_i && snoop_we_i[0] &&
                        (snoop_addr_i == CONSOLE_ADDR);
    assign console_valid_o = !w_con_empty;
    assign w_pass_stat = r_ovf ? STAT_ERR : STAT_PASS;

    riscof_console_fifo #(.WIDTH(8), .DEPTH(16)) u_console_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_con_push),
        .data_i  (snoop_wdata_i[7:0]),
        .pop_i   (console_valid_o && console_ready_i),
        .data_o  (console_data_o),
        .full_o  (w_con_full),
        .empty_o (w_con_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_ovf <= 1'b0;
        else if (w_con_push && w_con_full)
            r_ovf <= 1'b1;
    end
`else
    assign w_pass_stat = STAT_PASS;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_start     <= '0;
            r_end       <= '0;
            r_cur       <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
            done_o      <= 1'b0;
            status_o    <= STAT_RUN;
            sig_count_o <= '0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_wr && snoop_addr_i == SIG_START_ADDR)
                        r_start <= ADDR_WIDTH'(snoop_wdata_i);
                    if (w_wr && snoop_addr_i == SIG_END_ADDR)
                        r_end <= ADDR_WIDTH'(snoop_wdata_i);
                    // halt has priority over a coincident timeout
                    if (w_halt) begin
                        r_state <= S_CHECK;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state  <= S_DONE;
                        done_o   <= 1'b1;
                        status_o <= STAT_TIMEOUT;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_state  <= S_DONE;
                        done_o   <= 1'b1;
                        status_o <= STAT_ERR;
                    end else if (r_start == r_end) begin
                        r_state  <= S_DONE;
                        done_o   <= 1'b1;
                        status_o <= w_pass_stat;
                    end else begin
                        r_state    <= S_REQ;
                        r_cur      <= r_start;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= r_start;
                    end
                end
                S_REQ: begin
                    mem_req_o <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (mem_err_i) begin
                            r_state  <= S_DONE;
                            done_o   <= 1'b1;
                            status_o <= STAT_ERR;
                        end else begin
                            r_state     <= S_EMIT;
                            sig_data_o  <= mem_rdata_i;
                            sig_valid_o <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (sig_ready_i) begin
                        sig_valid_o <= 1'b0;
                        sig_count_o <= sig_count_o + 1'b1;
                        r_cur       <= w_next;
                        if (w_next == r_end) begin
                            r_state  <= S_DONE;
                            done_o   <= 1'b1;
                            status_o <= w_pass_stat;
                        end else begin
                            r_state    <= S_REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= w_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule
